multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
Parameters: none.
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: opcode  input  6  instr[31:26], taken from the instruction register.
REQ-004 SHALL have port: funct  input  6  instr[5:0], taken from the instruction register.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have ports, all outputs, 1 bit each: sig_RegWrite (register-file write enable), sig_MemWrite, sig_IRWrite, sig_IorD, sig_MemtoReg, sig_RegDst, sig_ALUSrcA, pc_en (PC load).
REQ-007 SHALL have ports: sig_ALUSrcB  output  2; sig_PCSrc  output  2; alu_control  output  3; state  output  4 (current state, for debug).

Function
REQ-008 SHALL be a Moore FSM; every output except pc_en SHALL depend only on the registered state.
REQ-009 SHALL encode states as follows: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-010 SHALL make these transitions:
- FETCH->DECODE.
- DECODE->MEMADR for lw (100011) or sw (101011).
- DECODE->EXEC for R-type (000000).
- DECODE->BEQ for 000100.
- DECODE->ADDIEX for 001000.
- DECODE->JUMP for 000010.
- DECODE->FETCH for any other opcode.
- MEMADR->MEMRD for lw; MEMADR->MEMWR for sw.
- MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, JUMP -> FETCH.
- Encodings 12-15 -> FETCH, with all strobes 0 while in them.
REQ-011 SHALL assert these outputs per state; every output not listed is 0:
- FETCH: IRWrite=1, pc write=1, ALUSrcB=01, ALUOp=00.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1.
- EXEC: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BEQ: ALUSrcA=1, ALUOp=01, PCSrc=01, branch=1.
- JUMP: PCSrc=10, pc write=1.
REQ-012 SHALL compute pc_en = pc write OR (branch AND zero), combinationally; zero SHALL be sampled only in BEQ.
REQ-013 SHALL derive alu_control combinationally from the internal 2-bit ALUOp:
- ALUOp=00 -> 010 (add).
- ALUOp=01 -> 110 (sub).
- ALUOp=10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- ALUOp=10 with any other funct -> 010.
REQ-014 SHALL give these latencies from FETCH entry to the next FETCH entry: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2 cycles.
REQ-015 SHALL assert sig_RegWrite for exactly one cycle per lw, R-type or addi instruction, and never for sw, beq, j or an unknown opcode.
REQ-016 SHALL assert sig_MemWrite for exactly one cycle per sw, and never otherwise.

Reset
REQ-017 SHALL load state=FETCH on any rising edge where reset_n=0, regardless of current state.
REQ-018 SHALL force every write strobe to 0 while reset_n=0 (sig_RegWrite, sig_MemWrite, sig_IRWrite, pc_en).
REQ-019 SHALL abandon an in-flight instruction on reset; no write SHALL complete after reset_n=0 is sampled.
REQ-020 SHALL perform FETCH in the first cycle after reset_n returns to 1.

Verification
REQ-021 SHALL cover: reset, then opcode=100011 held -> state sequence 0,1,2,3,4,0; sig_RegWrite=1 and MemtoReg=1 only in state 4.
REQ-022 SHALL cover: opcode=000000, funct=101010 -> states 0,1,6,7,0; alu_control=111 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-023 SHALL cover: opcode=000100 with zero=1 -> pc_en=1 and PCSrc=01 in state 8; with zero=0 -> pc_en=0 in state 8; back in FETCH on the next cycle.
REQ-024 SHALL cover: opcode=101011 -> states 0,1,2,5,0; MemWrite=1 and IorD=1 only in state 5; RegWrite never asserted.
REQ-025 SHALL cover: opcode=111111 -> states 0,1,0; then opcode=000010 -> states 0,1,11,0 with PCSrc=10 and pc_en=1 in state 11.
REQ-026 SHALL cover: reset_n=0 asserted while in state 3 (lw) -> state=0 on the next edge; no RegWrite pulse occurs; FETCH runs in the first cycle after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Purpose : Moore-style main controller for a multicycle MIPS-subset datapath
//           (lw, sw, R-type, beq, addi, j); steps the datapath one phase per cycle.
// Latency : FETCH-to-FETCH is lw 5, sw/R-type/addi 4, beq/j 3, unknown opcode 2 cycles.
// Backpressure: none; the controller advances every cycle and never stalls.
//
// Ports:
//   clock, reset_n        single rising-edge clock, synchronous active-low reset
//   opcode, funct         instr[31:26] / instr[5:0] from the instruction register
//   zero                  ALU zero flag, only consulted while in BEQ
//   sig_*                 datapath mux selects and write strobes
//   pc_en                 PC load = pc write OR (branch AND zero)
//   alu_control           3-bit ALU operation decoded from ALUOp and funct
//   state                 current FSM state, for debug
module multicycle_control (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       sig_RegWrite,
  output logic       sig_MemWrite,
  output logic       sig_IRWrite,
  output logic       sig_IorD,
  output logic       sig_MemtoReg,
  output logic       sig_RegDst,
  output logic       sig_ALUSrcA,
  output logic [1:0] sig_ALUSrcB,
  output logic [1:0] sig_PCSrc,
  output logic       pc_en,
  output logic [2:0] alu_control,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Per-state control word, registered alongside the state.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_nxt;
  ctrl_t  ctrl_q;

  // Control word for a given state; unused encodings 12-15 drive all zeros.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = 2'b00;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b00;
      end
      S_MEMRD: begin
        c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state decode. Opcode is only consulted in DECODE and MEMADR; the
  // instruction register holds it stable for the whole instruction.
  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // The control word is registered from the same next-state value as the
  // state itself, so it is always exactly decode_ctrl(state_q): a Moore
  // output with no decode logic between the flops and the pins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode_ctrl(state_nxt);
    end
  end

  // ALU decoder: ALUOp 10 defers to funct, ALUOp 11 is unused and adds.
  always_comb begin
    alu_control = ALU_ADD;
    case (ctrl_q.alu_op)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Write strobes are qualified by reset_n so that nothing commits in a
  // cycle where reset is being sampled, even though the state register
  // only clears on the edge.
  assign sig_RegWrite = ctrl_q.reg_write & reset_n;
  assign sig_MemWrite = ctrl_q.mem_write & reset_n;
  assign sig_IRWrite  = ctrl_q.ir_write  & reset_n;
  assign pc_en        = (ctrl_q.pc_write | (ctrl_q.branch & zero)) & reset_n;

  assign sig_IorD     = ctrl_q.iord;
  assign sig_MemtoReg = ctrl_q.mem_to_reg;
  assign sig_RegDst   = ctrl_q.reg_dst;
  assign sig_ALUSrcA  = ctrl_q.alu_src_a;
  assign sig_ALUSrcB  = ctrl_q.alu_src_b;
  assign sig_PCSrc    = ctrl_q.pc_src;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : directed scoreboard bench for multicycle_control.
// Latency : one expected record per clock cycle, checked mid-cycle.
// Backpressure: none; the monitor drains the queue every falling edge.
module tb_multicycle_control;

  logic       clock;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       sig_RegWrite, sig_MemWrite, sig_IRWrite, sig_IorD;
  logic       sig_MemtoReg, sig_RegDst, sig_ALUSrcA, pc_en;
  logic [1:0] sig_ALUSrcB, sig_PCSrc;
  logic [2:0] alu_control;
  logic [3:0] state;

  multicycle_control dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .sig_RegWrite (sig_RegWrite),
    .sig_MemWrite (sig_MemWrite),
    .sig_IRWrite  (sig_IRWrite),
    .sig_IorD     (sig_IorD),
    .sig_MemtoReg (sig_MemtoReg),
    .sig_RegDst   (sig_RegDst),
    .sig_ALUSrcA  (sig_ALUSrcA),
    .sig_ALUSrcB  (sig_ALUSrcB),
    .sig_PCSrc    (sig_PCSrc),
    .pc_en        (pc_en),
    .alu_control  (alu_control),
    .state        (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          step;
    logic [3:0]  st;
    logic [14:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Output vector packing:
  // {RegWrite, MemWrite, IRWrite, IorD, MemtoReg, RegDst, ALUSrcA,
  //  ALUSrcB[1:0], PCSrc[1:0], alu_control[2:0], pc_en}
  function automatic logic [14:0] o(input logic rw, input logic mw, input logic irw,
                                    input logic iord, input logic m2r, input logic rdst,
                                    input logic srca, input logic [1:0] srcb,
                                    input logic [1:0] pcsrc, input logic [2:0] alu,
                                    input logic pce);
    return {rw, mw, irw, iord, m2r, rdst, srca, srcb, pcsrc, alu, pce};
  endfunction

  // Drive one cycle's inputs just after the rising edge and record what the
  // outputs must look like for the remainder of this cycle.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [3:0] st, input logic [14:0] outs);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n = rst;
    opcode  = op;
    funct   = fn;
    zero    = z;
    step_no = step_no + 1;
    e.step  = step_no;
    e.st    = st;
    e.outs  = outs;
    exp_q.push_back(e);
  endtask

  // Monitor: compares on every falling edge for which a record is pending.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = exp_q.pop_front();
      act = {sig_RegWrite, sig_MemWrite, sig_IRWrite, sig_IorD, sig_MemtoReg,
             sig_RegDst, sig_ALUSrcA, sig_ALUSrcB, sig_PCSrc, alu_control, pc_en};
      n_checks = n_checks + 1;
      if (state === e.st && act === e.outs) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL step%0d: state=%0d outputs=%b, expected state=%0d outputs=%b",
                 e.step, state, act, e.st, e.outs);
      end
    end
  end

  initial begin
    logic [14:0] e_fetch, e_fetch_rst, e_decode, e_memadr, e_memrd, e_memwb;
    logic [14:0] e_memwb_rst, e_memwr, e_aluwb, e_addiwb, e_jump;
    int wait_cycles;

    e_fetch     = o(0,0,1,0,0,0,0,2'b01,2'b00,3'b010,1);
    e_fetch_rst = o(0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    e_decode    = o(0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    e_memadr    = o(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    e_memrd     = o(0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0);
    e_memwb     = o(1,0,0,0,1,0,0,2'b00,2'b00,3'b010,0);
    e_memwb_rst = o(0,0,0,0,1,0,0,2'b00,2'b00,3'b010,0);
    e_memwr     = o(0,1,0,1,0,0,0,2'b00,2'b00,3'b010,0);
    e_aluwb     = o(1,0,0,0,0,1,0,2'b00,2'b00,3'b010,0);
    e_addiwb    = o(1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    e_jump      = o(0,0,0,0,0,0,0,2'b00,2'b10,3'b010,1);

    reset_n = 1'b0;
    opcode  = 6'd0;
    funct   = 6'd0;
    zero    = 1'b0;

    // Reset: FETCH with strobes held off, then lw 0,1,2,3,4,0.
    cyc(0, OP_LW, 6'd0, 0, 4'd0, e_fetch_rst);
    cyc(1, OP_LW, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_LW, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_LW, 6'd0, 0, 4'd2, e_memadr);
    cyc(1, OP_LW, 6'd0, 0, 4'd3, e_memrd);
    cyc(1, OP_LW, 6'd0, 0, 4'd4, e_memwb);
    // R-type slt: 0,1,6,7,0 with alu_control 111 in EXEC.
    cyc(1, OP_R, 6'b101010, 0, 4'd0, e_fetch);
    cyc(1, OP_R, 6'b101010, 0, 4'd1, e_decode);
    cyc(1, OP_R, 6'b101010, 0, 4'd6, o(0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0));
    cyc(1, OP_R, 6'b101010, 0, 4'd7, e_aluwb);
    // beq taken (zero ignored in DECODE), then not taken.
    cyc(1, OP_BEQ, 6'd0, 1, 4'd0, e_fetch);
    cyc(1, OP_BEQ, 6'd0, 1, 4'd1, e_decode);
    cyc(1, OP_BEQ, 6'd0, 1, 4'd8, o(0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1));
    cyc(1, OP_BEQ, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_BEQ, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_BEQ, 6'd0, 0, 4'd8, o(0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
    // sw: 0,1,2,5,0.
    cyc(1, OP_SW, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_SW, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_SW, 6'd0, 0, 4'd2, e_memadr);
    cyc(1, OP_SW, 6'd0, 0, 4'd5, e_memwr);
    // Unknown opcode: 0,1,0; jump: 0,1,11,0.
    cyc(1, OP_BAD, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_BAD, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_J, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_J, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_J, 6'd0, 0, 4'd11, e_jump);
    // addi: 0,1,9,10,0.
    cyc(1, OP_ADDI, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_ADDI, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_ADDI, 6'd0, 0, 4'd9, e_memadr);
    cyc(1, OP_ADDI, 6'd0, 0, 4'd10, e_addiwb);
    // R-type sub.
    cyc(1, OP_R, 6'b100010, 0, 4'd0, e_fetch);
    cyc(1, OP_R, 6'b100010, 0, 4'd1, e_decode);
    cyc(1, OP_R, 6'b100010, 0, 4'd6, o(0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0));
    cyc(1, OP_R, 6'b100010, 0, 4'd7, e_aluwb);
    // lw abandoned by reset while in MEMRD: no MEMWB, FETCH after release.
    cyc(1, OP_LW, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_LW, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_LW, 6'd0, 0, 4'd2, e_memadr);
    cyc(0, OP_LW, 6'd0, 0, 4'd3, e_memrd);
    cyc(0, OP_R, 6'b100100, 0, 4'd0, e_fetch_rst);
    cyc(1, OP_R, 6'b100100, 0, 4'd0, e_fetch);
    // R-type and / or / unknown funct.
    cyc(1, OP_R, 6'b100100, 0, 4'd1, e_decode);
    cyc(1, OP_R, 6'b100100, 0, 4'd6, o(0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0));
    cyc(1, OP_R, 6'b100100, 0, 4'd7, e_aluwb);
    cyc(1, OP_R, 6'b100101, 0, 4'd0, e_fetch);
    cyc(1, OP_R, 6'b100101, 0, 4'd1, e_decode);
    cyc(1, OP_R, 6'b100101, 0, 4'd6, o(0,0,0,0,0,0,1,2'b00,2'b00,3'b001,0));
    cyc(1, OP_R, 6'b100101, 0, 4'd7, e_aluwb);
    cyc(1, OP_R, 6'b111111, 0, 4'd0, e_fetch);
    cyc(1, OP_R, 6'b111111, 0, 4'd1, e_decode);
    cyc(1, OP_R, 6'b111111, 0, 4'd6, o(0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0));
    cyc(1, OP_R, 6'b111111, 0, 4'd7, e_aluwb);
    // Reset sampled during MEMWB: the register write is suppressed.
    cyc(1, OP_LW, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_LW, 6'd0, 0, 4'd1, e_decode);
    cyc(1, OP_LW, 6'd0, 0, 4'd2, e_memadr);
    cyc(1, OP_LW, 6'd0, 0, 4'd3, e_memrd);
    cyc(0, OP_LW, 6'd0, 0, 4'd4, e_memwb_rst);
    cyc(0, OP_LW, 6'd0, 0, 4'd0, e_fetch_rst);
    cyc(1, OP_LW, 6'd0, 0, 4'd0, e_fetch);
    cyc(1, OP_LW, 6'd0, 0, 4'd1, e_decode);

    // Let the monitor drain, with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles = wait_cycles + 1;
    end
    if (exp_q.size() > 0) begin
      n_checks = n_checks + 1;
      $display("FAIL drain: %0d records still pending, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
